// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared state encodings, widths and clog2 helper for the TDM demux
package tdm_pkg;

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_EXPECT_A = 2'd1,
        ST_EXPECT_B = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear (clear wins over increment)
module sat_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux_2bit.sv
// rtl/tdm_demux_2bit.sv - locks to an A/B interleaved symbol lane and splits it into two registered channels
// Optional error statistics counter (err_count port) enabled by TDM_DEMUX_STATS_EN.
module tdm_demux_2bit
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MAX_MISS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             a_valid,
    output logic             b_valid,
    output logic             pair_valid,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_DEMUX_STATS_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int            MW        = clog2(MAX_MISS + 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic             pair_valid_q, pair_valid_d;
    logic             locked_q;
    logic             sync_err_q, sync_err_d;
    logic             miss_inc, miss_clr;
    logic [MW-1:0]    miss_cnt;

    sat_counter #(
        .WIDTH   (MW),
        .MAX_VAL (MAX_MISS)
    ) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .clr   (miss_clr),
        .count (miss_cnt)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        a_valid_d    = 1'b0;
        b_valid_d    = 1'b0;
        pair_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        miss_inc     = 1'b0;
        miss_clr     = 1'b0;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        a_d       = din;
                        a_valid_d = 1'b1;
                        miss_clr  = 1'b1;
                        state_d   = ST_EXPECT_B;
                    end
                end
                ST_EXPECT_B: begin
                    if (frame_sync) begin
                        // Re-anchor on the early sync but keep waiting for its B symbol.
                        a_d        = din;
                        a_valid_d  = 1'b1;
                        sync_err_d = 1'b1;
                    end else begin
                        b_d          = din;
                        b_valid_d    = 1'b1;
                        pair_valid_d = 1'b1;
                        state_d      = ST_EXPECT_A;
                    end
                end
                ST_EXPECT_A: begin
                    if (frame_sync) begin
                        a_d       = din;
                        a_valid_d = 1'b1;
                        miss_clr  = 1'b1;
                        state_d   = ST_EXPECT_B;
                    end else begin
                        sync_err_d = 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            miss_clr = 1'b1;
                            state_d  = ST_HUNT;
                        end else begin
                            miss_inc  = 1'b1;
                            a_d       = din;
                            a_valid_d = 1'b1;
                            state_d   = ST_EXPECT_B;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            a_q          <= '0;
            b_q          <= '0;
            a_valid_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            pair_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            a_valid_q    <= a_valid_d;
            b_valid_q    <= b_valid_d;
            pair_valid_q <= pair_valid_d;
            locked_q     <= (state_d != ST_HUNT);
            sync_err_q   <= sync_err_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign a_valid    = a_valid_q;
    assign b_valid    = b_valid_q;
    assign pair_valid = pair_valid_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

`ifdef TDM_DEMUX_STATS_EN
    sat_counter #(
        .WIDTH   (ERR_CNT_W),
        .MAX_VAL ((1 << ERR_CNT_W) - 1)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sync_err_d),
        .clr   (1'b0),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_tdm_demux_2bit.sv
// tb/tb_tdm_demux_2bit.sv - table-driven self-checking bench for tdm_demux_2bit
module tb_tdm_demux_2bit;

    logic       clk;
    logic       rst_n;
    logic [1:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [1:0] a_out;
    logic [1:0] b_out;
    logic       a_valid;
    logic       b_valid;
    logic       pair_valid;
    logic       locked;
    logic       sync_err;
`ifdef TDM_DEMUX_STATS_EN
    logic [7:0] err_count;
`endif

    int n_vec;
    int n_mis;

    tdm_demux_2bit #(
        .WIDTH    (2),
        .MAX_MISS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .a_out      (a_out),
        .b_out      (b_out),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .pair_valid (pair_valid),
        .locked     (locked),
        .sync_err   (sync_err)
`ifdef TDM_DEMUX_STATS_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp packing: {a[1:0], b[1:0], a_valid, b_valid, pair_valid, locked, sync_err}
    typedef struct packed {
        logic       v;
        logic       s;
        logic [1:0] d;
        logic [8:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int v, input int s, input int d, input int a, input int b,
                                input int av, input int bv, input int pv, input int lk, input int er);
        vec_t r;
        r.v   = v[0];
        r.s   = s[0];
        r.d   = d[1:0];
        r.exp = {a[1:0], b[1:0], av[0], bv[0], pv[0], lk[0], er[0]};
        return r;
    endfunction

    function automatic logic [8:0] pk(input int a, input int b, input int av, input int bv,
                                      input int pv, input int lk, input int er);
        return {a[1:0], b[1:0], av[0], bv[0], pv[0], lk[0], er[0]};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {a_out, b_out, a_valid, b_valid, pair_valid, locked, sync_err};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got a=%0d b=%0d av=%b bv=%b pv=%b lk=%b err=%b, want a=%0d b=%0d av=%b bv=%b pv=%b lk=%b err=%b",
                     name, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic [1:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 2'd0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        int aval;
        int bval;
        int prev_b;
        n_vec = 0;
        n_mis = 0;

        //            v  s  d   a  b  av bv pv lk er
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 3, 3, 0, 1, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 1, 3, 1, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 1, 2, 2, 1, 1, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 2, 0, 0, 1, 1, 1, 0));
        vq.push_back(mk(0, 0, 3, 2, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 1, 1, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 3, 1, 3, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 0, 2, 2, 3, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 2, 0, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 0, 3, 2, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 1, 0));
        vq.push_back(mk(1, 1, 2, 2, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 3, 2, 3, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 1, 0, 1, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 1, 2, 2, 1, 1, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 3, 2, 3, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 0, 1, 1, 3, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 0, 2, 2, 0, 1, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 1, 2, 1, 0, 1, 1, 1, 0));
        vq.push_back(mk(0, 1, 3, 2, 1, 0, 0, 0, 1, 0));

        do_reset();
        check("reset_state", pk(0, 0, 0, 0, 0, 0, 0));
`ifdef TDM_DEMUX_STATS_EN
        n_vec++;
        if (err_count !== 8'd0) begin
            n_mis++;
            $display("FAIL err_count_reset: got %0d want 0", err_count);
        end
`endif

        for (int i = 0; i < vq.size(); i++) begin
            beat(vq[i].v, vq[i].s, vq[i].d);
            check($sformatf("table[%0d]", i), vq[i].exp);
        end

        // Gaps of 0, 1 and 5 idle cycles between A and B.
        do_reset();
        prev_b = 0;
        for (int g = 0; g < 3; g++) begin
            gap  = (g == 0) ? 0 : ((g == 1) ? 1 : 5);
            aval = g + 1;
            bval = 2 - g;
            beat(1'b1, 1'b1, 2'(aval));
            check($sformatf("gap%0d_a", gap), pk(aval, prev_b, 1, 0, 0, 1, 0));
            for (int k = 0; k < gap; k++) begin
                beat(1'b0, (k % 2) == 0, 2'(k));
                check($sformatf("gap%0d_idle%0d", gap, k), pk(aval, prev_b, 0, 0, 0, 1, 0));
            end
            beat(1'b1, 1'b0, 2'(bval));
            check($sformatf("gap%0d_b", gap), pk(aval, bval, 0, 1, 1, 1, 0));
            prev_b = bval;
        end

        // Reset asserted between A and B must clear outputs without waiting for a clock edge.
        do_reset();
        beat(1'b1, 1'b1, 2'd3);
        check("pre_reset_a", pk(3, 0, 1, 0, 0, 1, 0));
        din_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", pk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0, 2'd1);
        check("post_reset_hunt", pk(0, 0, 0, 0, 0, 0, 0));
        beat(1'b1, 1'b1, 2'd2);
        check("post_reset_relock", pk(2, 0, 1, 0, 0, 1, 0));

`ifdef TDM_DEMUX_STATS_EN
        do_reset();
        beat(1'b1, 1'b1, 2'd1);
        for (int k = 1; k <= 300; k++) begin
            beat(1'b1, 1'b1, 2'(k));
            if (k == 254 || k == 255 || k == 300) begin
                n_vec++;
                if (err_count !== 8'((k > 255) ? 255 : k)) begin
                    n_mis++;
                    $display("FAIL err_count_after_%0d: got %0d want %0d", k, err_count, (k > 255) ? 255 : k);
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/tdm_demux_2bit.md
# tdm_demux_2bit

Receive-side counterpart of the lab's 2-bit selector path. A 2-bit time-division stream carries alternating channel-A and channel-B symbols on one lane, with a frame-sync flag on each A slot. This block locks to that stream, de-interleaves it into two registered 2-bit channels, and tracks sync loss with a flywheel miss counter. It sits between the serial link lane and the per-channel consumers.

## Interface
Parameters:
- WIDTH, 2, symbol width in bits.
- MAX_MISS, 3, consecutive missing frame-syncs tolerated before dropping lock; range 1–15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  incoming symbol.
- din_valid  input  1  din is a valid beat this cycle.
- frame_sync  input  1  qualifies a valid beat as the channel-A slot.
- a_out  output  WIDTH  last captured channel-A symbol.
- b_out  output  WIDTH  last captured channel-B symbol.
- a_valid  output  1  one-cycle pulse: a_out updated.
- b_valid  output  1  one-cycle pulse: b_out updated.
- pair_valid  output  1  one-cycle pulse: a complete A/B pair is now on a_out/b_out.
- locked  output  1  high outside HUNT.
- sync_err  output  1  one-cycle pulse on any framing violation.
- err_count  output  8  only with TDM_DEMUX_STATS_EN; see Configuration.

## Operation
- States: HUNT, EXPECT_A, EXPECT_B. Cycles with din_valid=0 change nothing; all pulses are low.
- HUNT: a beat without sync is discarded. A beat with sync captures A, clears the miss counter, and moves to EXPECT_B.
- EXPECT_B, beat without sync: captures B, pulses b_valid and pair_valid, and moves to EXPECT_A.
- EXPECT_B, beat with sync: unexpected sync. Captures the beat as A, pulses a_valid and sync_err, and stays in EXPECT_B. No pair_valid.
- EXPECT_A, beat with sync: captures A, clears the miss counter, and moves to EXPECT_B.
- EXPECT_A, beat without sync (miss): pulses sync_err and increments the miss counter.
  - If the new count is below MAX_MISS (flywheel): captures the beat as A, pulses a_valid, and moves to EXPECT_B.
  - If the new count equals MAX_MISS: discards the beat, moves to HUNT, and clears the counter.
- The miss counter is clog2(MAX_MISS+1) bits wide and never exceeds MAX_MISS.
- a_out and b_out hold their values between captures.

## Timing
- Outputs are registered. A beat accepted on edge N is visible on a_out/b_out, with its pulse, during cycle N+1; latency is 1 cycle.
- pair_valid is asserted in the same cycle as b_valid.
- Back-to-back valid beats are supported at full rate: one symbol per cycle, no stall output.
- Reset state: HUNT, miss counter 0. Outputs a_out, b_out, a_valid, b_valid, pair_valid, locked, sync_err and err_count are all 0.
- Reset asserted mid-frame clears everything immediately. After release, the next beat is evaluated in HUNT.

## Configuration
- TDM_DEMUX_STATS_EN defined:
  - err_count port exists: an 8-bit counter incremented on every sync_err pulse.
  - Saturates at 255 and clears only on reset.
- TDM_DEMUX_STATS_EN undefined: the err_count port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package tdm_pkg holds:
  - state encodings ST_HUNT=2'd0, ST_EXPECT_A=2'd1, ST_EXPECT_B=2'd2;
  - ERR_CNT_W=8;
  - the clog2 helper function.
- One sub-module, sat_counter (parameters: width, max value; ports: inc, clr, count). It is used for the miss counter and for err_count.

## Test plan
- Lock and de-interleave:
  - Stimulus: reset; beats (3,sync) (1) (2,sync) (0).
  - Required: a_out=3 then b_out=1 with pair_valid; a_out=2 then b_out=0 with pair_valid. locked rises one cycle after the first beat.
- Hunt discard: beats (1) (2) before the first sync → no valid pulses, locked=0, both outputs stay 0.
- Stall transparency: insert din_valid=0 gaps of 0, 1 and 5 cycles between A and B → pairs identical to the gap-free run; no spurious pulses.
- Flywheel and loss, MAX_MISS=3:
  - Stimulus: lock, then A slots 1 and 2 arrive without sync; B slots are normal.
  - Required: both are captured as A with sync_err; locked stays 1.
  - Third consecutive miss: beat discarded, locked=0.
  - A later sync relocks.
- Unexpected sync: in EXPECT_B send (2,sync) → a_out=2, sync_err=1, no pair_valid. The next non-sync beat becomes B with pair_valid.
- Reset mid-frame and stats:
  - Stimulus: assert rst_n=0 between A and B.
  - Required: all outputs 0 immediately, asynchronously.
  - With TDM_DEMUX_STATS_EN: 300 forced errors → err_count=255.
